// File: rtl/memory_array.sv
// ---------------------------------------------------------------------------
// memory_array : single-port word memory behind an IDLE/ACCESS/DONE handshake,
//                with per-word written flags that gate reads.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_t state;
  state_t next_state;

  logic             op_rw;
  logic [AW-1:0]    op_addr;
  logic [WIDTH-1:0] op_data;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic             err_q;

  logic in_range;
  logic accept;
  logic wr_en;

  assign in_range = ({1'b0, op_addr} < DEPTH_W);
  assign accept   = (state == IDLE) && sel;
  assign wr_en    = (state == ACCESS) && op_rw && in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so bus activity while busy is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rw   <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
    end else if (accept) begin
      op_rw   <= rw;
      op_addr <= addr;
      op_data <= data_in;
    end
  end

  // Storage itself is not reset; the written flags hide stale contents.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[op_addr] <= op_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written  <= '0;
      data_out <= '0;
      err_q    <= 1'b0;
    end else if (state == ACCESS) begin
      if (!in_range) begin
        err_q <= 1'b1;
      end else if (op_rw) begin
        written[op_addr] <= 1'b1;
        err_q            <= 1'b0;
      end else if (written[op_addr]) begin
        data_out <= mem[op_addr];
        err_q    <= 1'b0;
      end else begin
        data_out <= '0;
        err_q    <= 1'b1;
      end
    end else begin
      err_q <= 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q && (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_memory_array.sv
// Self-checking bench for memory_array: main instance (WIDTH=8, DEPTH=12) plus
// two parameter-sweep instances.
`default_nettype none

module tb_memory_array;

  logic clk;
  logic rst;

  // main instance
  logic       sel, rw;
  logic [3:0] addr;
  logic [7:0] data_in, data_out;
  logic       busy, done, err;

  // sweep instance 1
  logic       s1_sel, s1_rw;
  logic [0:0] s1_addr;
  logic [0:0] s1_din, s1_dout;
  logic       s1_busy, s1_done, s1_err;

  // sweep instance 2
  logic        s2_sel, s2_rw;
  logic [7:0]  s2_addr;
  logic [31:0] s2_din, s2_dout;
  logic        s2_busy, s2_done, s2_err;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[14];

  memory_array #(.WIDTH(8), .DEPTH(12)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .err(err)
  );

  memory_array #(.WIDTH(1), .DEPTH(2)) dut_s1 (
    .clk(clk), .rst(rst), .sel(s1_sel), .rw(s1_rw), .addr(s1_addr), .data_in(s1_din),
    .data_out(s1_dout), .busy(s1_busy), .done(s1_done), .err(s1_err)
  );

  memory_array #(.WIDTH(32), .DEPTH(256)) dut_s2 (
    .clk(clk), .rst(rst), .sel(s2_sel), .rw(s2_rw), .addr(s2_addr), .data_in(s2_din),
    .data_out(s2_dout), .busy(s2_busy), .done(s2_done), .err(s2_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", 64'(data_out), 64'(e.dout));
          check("err", 64'(err), 64'(e.err));
        end
      end else begin
        check("err_idle", 64'(err), 64'd0);
      end
    end
  end

  task automatic main_op(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee);
    int lat;
    exp_t e;
    lat = 0;
    @(negedge clk);
    sel = 1'b1; rw = w; addr = a; data_in = d;
    e.dout = ed; e.err = ee;
    exp_q.push_back(e);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      sel = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", 64'(lat), 64'd2);
  endtask

  task automatic s1_op(input logic w, input logic [0:0] a, input logic [0:0] d,
                       input logic [0:0] ed, input logic ee);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    s1_sel = 1'b1; s1_rw = w; s1_addr = a; s1_din = d;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      s1_sel = 1'b0;
      if (s1_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("s1_done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("s1_dout", 64'(s1_dout), 64'(ed));
      check("s1_err", 64'(s1_err), 64'(ee));
    end
  endtask

  task automatic s2_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    s2_sel = 1'b1; s2_rw = w; s2_addr = a; s2_din = d;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      s2_sel = 1'b0;
      if (s2_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("s2_done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("s2_dout", 64'(s2_dout), 64'(ed));
      check("s2_err", 64'(s2_err), 64'(ee));
    end
  endtask

  initial begin
    exp_t e;
    n_cmp = 0;
    n_bad = 0;

    //          rw    addr   din     dout    err
    vecs[0]  = '{1'b0, 4'd7,  8'h00, 8'h00, 1'b1};  // unwritten read after reset
    vecs[1]  = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 4'd13, 8'hFF, 8'hA5, 1'b1};  // out of range write
    vecs[4]  = '{1'b0, 4'd13, 8'h00, 8'hA5, 1'b1};  // out of range read
    vecs[5]  = '{1'b1, 4'd3,  8'h5A, 8'hA5, 1'b0};  // data_out holds across write
    vecs[6]  = '{1'b0, 4'd3,  8'h00, 8'h5A, 1'b0};
    vecs[7]  = '{1'b1, 4'd11, 8'h77, 8'h5A, 1'b0};  // last legal address
    vecs[8]  = '{1'b0, 4'd11, 8'h00, 8'h77, 1'b0};
    vecs[9]  = '{1'b1, 4'd12, 8'h12, 8'h77, 1'b1};  // first illegal address
    vecs[10] = '{1'b0, 4'd12, 8'h00, 8'h77, 1'b1};
    vecs[11] = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 4'd0,  8'hC3, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  8'h00, 8'hC3, 1'b0};

    rst = 1'b1;
    sel = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
    s1_sel = 1'b0; s1_rw = 1'b0; s1_addr = '0; s1_din = '0;
    s2_sel = 1'b0; s2_rw = 1'b0; s2_addr = '0; s2_din = '0;

    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      main_op(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].dout, vecs[i].err);
    end

    // Requests while busy are ignored; sel held high starts the next op right after DONE.
    @(negedge clk);
    sel = 1'b1; rw = 1'b1; addr = 4'd5; data_in = 8'h11;
    e.dout = 8'hC3; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    check("busy_access", 64'(busy), 64'd1);
    sel = 1'b0; rw = 1'b0; addr = 4'd6; data_in = 8'h22;
    #2;
    sel = 1'b1; rw = 1'b0; addr = 4'd5;
    @(negedge clk);
    check("busy_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("busy_idle_gap", 64'(busy), 64'd0);
    e.dout = 8'h11; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    check("busy_restart", 64'(busy), 64'd1);
    sel = 1'b0;
    @(negedge clk);
    check("busy_second_done", 64'(done), 64'd1);
    main_op(1'b0, 4'd6, 8'h00, 8'h00, 1'b1);

    // Reset during ACCESS aborts the write and clears written flags.
    @(negedge clk);
    sel = 1'b1; rw = 1'b1; addr = 4'd2; data_in = 8'h3C;
    @(negedge clk);
    sel = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_data_out", 64'(data_out), 64'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    main_op(1'b0, 4'd2, 8'h00, 8'h00, 1'b1);
    main_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b1);
    main_op(1'b1, 4'd2, 8'h3C, 8'h00, 1'b0);
    main_op(1'b0, 4'd2, 8'h00, 8'h3C, 1'b0);

    // Parameter sweep: walking ones to every address, then read back.
    for (int a = 0; a < 2; a++) s1_op(1'b1, 1'(a), 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 2; a++) s1_op(1'b0, 1'(a), 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 256; a++) s2_op(1'b1, 8'(a), 32'd1 << (a % 32), 32'd0, 1'b0);
    for (int a = 0; a < 256; a++) s2_op(1'b0, 8'(a), 32'd0, 32'd1 << (a % 32), 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_array.md
MEMORY_ARRAY -- requirements
Module: memory_array

Interface
REQ-001 Parameter WIDTH, default 8, bits per word; legal range 1-64.
REQ-002 Parameter DEPTH, default 16, number of words; legal range 2-256, not required to be a power of two.
REQ-003 Derived constant AW = $clog2(DEPTH), address width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sel  input  1  operation request, sampled only in IDLE.
REQ-007 rw  input  1  operation type: 1 = write, 0 = read.
REQ-008 addr  input  AW  word address.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  error status of the completing operation, valid only while done=1.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-015 IDLE, sel=1 at edge k: latch rw, addr and data_in into internal registers, go to ACCESS; sel=0: stay in IDLE.
REQ-016 ACCESS at edge k+1: perform the latched operation, go to DONE unconditionally.
REQ-017 DONE at edge k+2: go to IDLE unconditionally.
REQ-018 busy=1 in ACCESS and DONE, 0 in IDLE; done=1 only in DONE.
REQ-019 Latency: done is high during the cycle after edge k+1; maximum throughput is one operation per 3 cycles.
REQ-020 sel, rw, addr and data_in SHALL be ignored outside IDLE; sel held high through DONE starts the next operation at the first edge in IDLE.
REQ-021 Write, addr < DEPTH: mem[addr] <= latched data and written[addr] <= 1 at edge k+1; data_out unchanged; err=0.
REQ-022 Read, addr < DEPTH, written[addr]=1: data_out <= mem[addr] at edge k+1; err=0.
REQ-023 Read, addr < DEPTH, written[addr]=0: data_out <= 0; err=1.
REQ-024 Any operation with addr >= DEPTH: no memory or written-flag change; data_out unchanged; err=1.
REQ-025 data_out SHALL hold its value between reads, including across writes to the same address.
REQ-026 A read issued after a write to the same address SHALL return the new data.
REQ-027 err SHALL be 0 whenever done=0.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, busy=0, done=0, err=0, data_out=0, and all written[] flags to 0, independent of clk.
REQ-029 Memory word contents are not reset; they are unobservable until rewritten because written[] gates reads.
REQ-030 rst asserted during ACCESS before edge k+1 SHALL abort the operation with no memory update; no done pulse is issued.
REQ-031 After rst deasserts, the first sel=1 sampled in IDLE starts a normal operation.

Verification
REQ-032 Write then read: write 0xA5 to addr 3, then read addr 3 -> done pulses 2 cycles after each accepted sel; data_out=0xA5; err=0 on both.
REQ-033 Unwritten read: after reset, read addr 7 -> data_out=0x00, err=1 during done.
REQ-034 Out of range: DEPTH=12, write 0xFF to addr 13, then read addr 13 -> err=1 on both; data_out unchanged; no written flag set.
REQ-035 Request ignored while busy: during ACCESS, toggle sel, addr and data_in -> only the originally latched operation completes; with sel held high, the next operation starts exactly one cycle after done.
REQ-036 Reset mid-operation: write 0x3C to addr 2, assert rst in ACCESS, release rst, read addr 2 -> err=1, data_out=0x00.
REQ-037 Parameter sweep: WIDTH=1/DEPTH=2 and WIDTH=32/DEPTH=256 -> write walking-ones patterns to every address and read them back bit-exact with err=0.
